dtack_wait_state_controller: RTL and testbench

DTACK_WAIT_STATE_CONTROLLER -- requirements
Module: dtack_wait_state_controller

---
 rtl/dtack_wait_state_controller.sv | 196 +++++++++++++++++++
 tb/tb_dtack_wait_state_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtack_wait_state_controller.sv
// dtack_wait_state_controller
// Generates the 68k DTACK_L / BERR_L handshake for each bus cycle. A cycle
// starts when AS_L is sampled low in IDLE. The address region is chosen from
// the decoder selects (priority ROM > RAM > IO > CAN > DRAM). Fixed-wait
// regions acknowledge after their wait count. DRAM acknowledges on
// DramReady_H. A cycle with no select can only end by bus-error timeout.
//
// Ports:
//   Clock, Reset_H         clock and synchronous active-high reset
//   AS_L, Address          CPU address strobe (active low) and address bus
//   *Select_H              decoder region selects
//   DramReady_H            DRAM controller data-ready
//   TimeoutClear_H         clears the sticky Timeout_H flag
//   DTACK_L, BERR_L        acknowledge / bus error to CPU (active low)
//   Busy_H                 bus cycle in progress
//   Timeout_H              sticky timeout flag
//   FaultAddress           address of the cycle that last timed out
module dtack_wait_state_controller #(
    parameter int unsigned ROM_WAIT       = 0,
    parameter int unsigned RAM_WAIT       = 0,
    parameter int unsigned IO_WAIT        = 3,
    parameter int unsigned CAN_WAIT       = 7,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset_H,
    input  logic        AS_L,
    input  logic [31:0] Address,
    input  logic        OnChipRomSelect_H,
    input  logic        OnChipRamSelect_H,
    input  logic        IOSelect_H,
    input  logic        CanBusSelect_H,
    input  logic        DramSelect_H,
    input  logic        DramReady_H,
    input  logic        TimeoutClear_H,
    output logic        DTACK_L,
    output logic        BERR_L,
    output logic        Busy_H,
    output logic        Timeout_H,
    output logic [31:0] FaultAddress
);

    typedef enum logic [2:0] {
        ST_BLOCKED,
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        RG_ROM,
        RG_RAM,
        RG_IO,
        RG_CAN,
        RG_DRAM,
        RG_NONE
    } region_t;

    state_t      state;
    region_t     region_q;
    logic [31:0] addr_q;
    logic [3:0]  wait_cnt;
    logic [7:0]  to_cnt;

    region_t     sel_region_c;
    logic [3:0]  sel_wait_c;
    logic        start_ack_c;
    logic        wait_done_c;
    logic        timeout_hit_c;

    // Region decode with fixed priority, and its wait count
    always_comb begin
        sel_region_c = RG_NONE;
        sel_wait_c   = 4'd0;
        if (OnChipRomSelect_H) begin
            sel_region_c = RG_ROM;
            sel_wait_c   = 4'(ROM_WAIT);
        end else if (OnChipRamSelect_H) begin
            sel_region_c = RG_RAM;
            sel_wait_c   = 4'(RAM_WAIT);
        end else if (IOSelect_H) begin
            sel_region_c = RG_IO;
            sel_wait_c   = 4'(IO_WAIT);
        end else if (CanBusSelect_H) begin
            sel_region_c = RG_CAN;
            sel_wait_c   = 4'(CAN_WAIT);
        end else if (DramSelect_H) begin
            sel_region_c = RG_DRAM;
        end
    end

    // Acknowledge on the starting edge: zero-wait fixed region or DRAM already ready
    always_comb begin
        start_ack_c = 1'b0;
        if (sel_region_c == RG_DRAM) begin
            start_ack_c = DramReady_H;
        end else if (sel_region_c != RG_NONE) begin
            start_ack_c = (sel_wait_c == 4'd0);
        end
    end

    // Completion and timeout conditions evaluated on a WAIT edge.
    // The wait counter holds the edges remaining, so a value of 1 means this edge.
    always_comb begin
        wait_done_c = 1'b0;
        if (region_q == RG_DRAM) begin
            wait_done_c = DramReady_H;
        end else if (region_q != RG_NONE) begin
            wait_done_c = (wait_cnt <= 4'd1);
        end
        timeout_hit_c = ((9'(to_cnt) + 9'd1) >= 9'(TIMEOUT_CYCLES));
    end

    // Bus cycle FSM with registered handshake outputs
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state        <= ST_BLOCKED;
            region_q     <= RG_NONE;
            addr_q       <= 32'd0;
            wait_cnt     <= 4'd0;
            to_cnt       <= 8'd0;
            DTACK_L      <= 1'b1;
            BERR_L       <= 1'b1;
            Busy_H       <= 1'b0;
            Timeout_H    <= 1'b0;
            FaultAddress <= 32'd0;
        end else begin
            // Clear first so that a timeout on the same edge overrides it
            if (TimeoutClear_H) begin
                Timeout_H <= 1'b0;
            end

            case (state)
                ST_BLOCKED: begin
                    if (AS_L) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (!AS_L) begin
                        region_q <= sel_region_c;
                        addr_q   <= Address;
                        wait_cnt <= sel_wait_c;
                        to_cnt   <= 8'd0;
                        Busy_H   <= 1'b1;
                        if (start_ack_c) begin
                            state   <= ST_ACK;
                            DTACK_L <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    to_cnt <= to_cnt + 8'd1;
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                    // Abort beats acknowledge, acknowledge beats timeout
                    if (AS_L) begin
                        state  <= ST_IDLE;
                        Busy_H <= 1'b0;
                    end else if (wait_done_c) begin
                        state   <= ST_ACK;
                        DTACK_L <= 1'b0;
                    end else if (timeout_hit_c) begin
                        state        <= ST_ERR;
                        BERR_L       <= 1'b0;
                        Timeout_H    <= 1'b1;
                        FaultAddress <= addr_q;
                    end
                end

                ST_ACK, ST_ERR: begin
                    if (AS_L) begin
                        state   <= ST_IDLE;
                        DTACK_L <= 1'b1;
                        BERR_L  <= 1'b1;
                        Busy_H  <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_BLOCKED;
                    DTACK_L <= 1'b1;
                    BERR_L  <= 1'b1;
                    Busy_H  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtack_wait_state_controller.sv
// tb_dtack_wait_state_controller
// Self-checking bench: table-driven bus cycles, hand-written corner sequences
// (timeout clear, set/clear coincidence, reset mid-cycle) and random cycles
// checked against a transaction-level expectation model.
module tb_dtack_wait_state_controller;

    localparam int TO     = 255;
    localparam int W_ROM  = 0;
    localparam int W_RAM  = 0;
    localparam int W_IO   = 3;
    localparam int W_CAN  = 7;

    // select vector bit order: [0] ROM, [1] RAM, [2] IO, [3] CAN, [4] DRAM
    localparam logic [4:0] S_ROM  = 5'b00001;
    localparam logic [4:0] S_RAM  = 5'b00010;
    localparam logic [4:0] S_IO   = 5'b00100;
    localparam logic [4:0] S_CAN  = 5'b01000;
    localparam logic [4:0] S_DRAM = 5'b10000;

    logic        Clock;
    logic        Reset_H;
    logic        AS_L;
    logic [31:0] Address;
    logic        OnChipRomSelect_H;
    logic        OnChipRamSelect_H;
    logic        IOSelect_H;
    logic        CanBusSelect_H;
    logic        DramSelect_H;
    logic        DramReady_H;
    logic        TimeoutClear_H;
    logic        DTACK_L;
    logic        BERR_L;
    logic        Busy_H;
    logic        Timeout_H;
    logic [31:0] FaultAddress;

    int checks;
    int errors;

    logic        exp_to;
    logic [31:0] exp_fault;
    bit          rand_clr;

    dtack_wait_state_controller #(
        .ROM_WAIT      (W_ROM),
        .RAM_WAIT      (W_RAM),
        .IO_WAIT       (W_IO),
        .CAN_WAIT      (W_CAN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clock            (Clock),
        .Reset_H          (Reset_H),
        .AS_L             (AS_L),
        .Address          (Address),
        .OnChipRomSelect_H(OnChipRomSelect_H),
        .OnChipRamSelect_H(OnChipRamSelect_H),
        .IOSelect_H       (IOSelect_H),
        .CanBusSelect_H   (CanBusSelect_H),
        .DramSelect_H     (DramSelect_H),
        .DramReady_H      (DramReady_H),
        .TimeoutClear_H   (TimeoutClear_H),
        .DTACK_L          (DTACK_L),
        .BERR_L           (BERR_L),
        .Busy_H           (Busy_H),
        .Timeout_H        (Timeout_H),
        .FaultAddress     (FaultAddress)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] addr;
        int          r;      // edge offset at which AS_L is first sampled high
        int          d;      // edge offset at which DramReady_H is high (-1 never)
        int          gap;    // extra idle edges after the cycle
        int          dfrom;  // expected first DTACK_L-low edge (-1 none)
        int          bfrom;  // expected first BERR_L-low edge (-1 none)
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string what, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", what, got, want);
        end
    endtask

    task automatic chk_all(input string tag, input logic dt, input logic be, input logic bz);
        chk({tag, " DTACK_L"}, 32'(DTACK_L), 32'(dt));
        chk({tag, " BERR_L"}, 32'(BERR_L), 32'(be));
        chk({tag, " Busy_H"}, 32'(Busy_H), 32'(bz));
        chk({tag, " Timeout_H"}, 32'(Timeout_H), 32'(exp_to));
        chk({tag, " FaultAddress"}, FaultAddress, exp_fault);
    endtask

    task automatic drive_sel(input logic [4:0] sel);
        OnChipRomSelect_H = sel[0];
        OnChipRamSelect_H = sel[1];
        IOSelect_H        = sel[2];
        CanBusSelect_H    = sel[3];
        DramSelect_H      = sel[4];
    endtask

    // Expected outcome of a cycle, derived from the region rules only
    function automatic void model(input logic [4:0] sel, input int r, input int d,
                                  output int dfrom, output int bfrom);
        int ack_at;
        ack_at = -1;
        if (sel[0])      ack_at = W_ROM;
        else if (sel[1]) ack_at = W_RAM;
        else if (sel[2]) ack_at = W_IO;
        else if (sel[3]) ack_at = W_CAN;
        else if (sel[4]) ack_at = d;
        dfrom = -1;
        bfrom = -1;
        if (ack_at >= 0 && ack_at <= TO && ack_at < r) dfrom = ack_at;
        else if (TO < r) bfrom = TO;
    endfunction

    // One bus cycle starting at edge offset 0, followed by idle edges
    task automatic run_txn(input string name, input logic [4:0] sel, input logic [31:0] addr,
                           input int r, input int d, input int gap,
                           input int dfrom, input int bfrom, input int clr_k);
        logic clr;
        for (int k = 0; k <= r + gap; k++) begin
            AS_L        = (k < r) ? 1'b0 : 1'b1;
            drive_sel((k < r) ? sel : 5'b0);
            Address     = addr;
            DramReady_H = (k == d);
            clr = rand_clr ? ($urandom_range(0, 15) == 0) : (k == clr_k);
            TimeoutClear_H = clr;
            @(posedge Clock);
            #1;
            if (k == bfrom) begin
                exp_to    = 1'b1;
                exp_fault = addr;
            end else if (clr) begin
                exp_to = 1'b0;
            end
            chk_all($sformatf("%s edge %0d", name, k),
                    !(dfrom >= 0 && k >= dfrom && k < r),
                    !(bfrom >= 0 && k >= bfrom && k < r),
                    (k < r));
        end
        TimeoutClear_H = 1'b0;
        DramReady_H    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dfrom;
        int bfrom;
        logic [4:0] sel;
        int r;
        int d;

        checks    = 0;
        errors    = 0;
        rand_clr  = 1'b0;
        exp_to    = 1'b0;
        exp_fault = 32'd0;

        Reset_H        = 1'b1;
        AS_L           = 1'b1;
        Address        = 32'd0;
        DramReady_H    = 1'b0;
        TimeoutClear_H = 1'b0;
        drive_sel(5'b0);

        // {sel, addr, r, d, gap, dfrom, bfrom}
        tbl[0]  = '{S_IO,          32'h0040_0010, 6,   -1,  0, 3,   -1};
        tbl[1]  = '{S_ROM,         32'h0000_0100, 2,   -1,  0, 0,   -1};
        tbl[2]  = '{S_ROM,         32'h0000_0104, 2,   -1,  0, 0,   -1};
        tbl[3]  = '{S_RAM,         32'h0010_0000, 1,   -1,  1, 0,   -1};
        tbl[4]  = '{S_CAN,         32'h0060_0000, 10,  -1,  1, 7,   -1};
        tbl[5]  = '{S_CAN,         32'h0060_0004, 3,   -1,  1, -1,  -1};
        tbl[6]  = '{S_ROM | S_IO,  32'h0000_0200, 4,   -1,  0, 0,   -1};
        tbl[7]  = '{S_IO | S_CAN,  32'h0040_0020, 9,   -1,  0, 3,   -1};
        tbl[8]  = '{S_CAN | S_DRAM,32'h0060_0008, 9,   1,   0, 7,   -1};
        tbl[9]  = '{S_DRAM,        32'h0800_0000, 8,   5,   0, 5,   -1};
        tbl[10] = '{S_DRAM,        32'h0800_0010, 2,   0,   0, 0,   -1};
        tbl[11] = '{S_IO,          32'h0040_0030, 3,   -1,  0, -1,  -1};
        tbl[12] = '{S_DRAM,        32'h0800_0020, 258, 255, 1, 255, -1};
        tbl[13] = '{S_DRAM,        32'h0800_0030, 258, 256, 1, -1,  255};
        tbl[14] = '{5'b0,          32'h0050_0000, 258, -1,  2, -1,  255};

        // Reset values
        repeat (2) @(posedge Clock);
        #1;
        chk_all("reset", 1'b1, 1'b1, 1'b0);
        Reset_H = 1'b0;
        // Leave BLOCKED with AS_L high
        run_txn("unblock", 5'b0, 32'd0, 0, -1, 0, -1, -1, -1);

        for (int i = 0; i < 15; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].addr, tbl[i].r, tbl[i].d,
                    tbl[i].gap, tbl[i].dfrom, tbl[i].bfrom, -1);
        end

        // Timeout flag cleared while idle; FaultAddress holds
        run_txn("clear", 5'b0, 32'hdead_beef, 0, -1, 2, -1, -1, 1);

        // Timeout set and clear on the same edge: set wins
        run_txn("setclr", 5'b0, 32'h0050_0040, 258, -1, 1, -1, 255, 255);

        // Reset in WAIT with AS_L held low
        for (int k = 0; k < 3; k++) begin
            AS_L    = 1'b0;
            Address = 32'h0060_1000;
            drive_sel(S_CAN);
            @(posedge Clock);
            #1;
            chk_all($sformatf("prerst edge %0d", k), 1'b1, 1'b1, 1'b1);
        end
        Reset_H = 1'b1;
        @(posedge Clock);
        #1;
        exp_to    = 1'b0;
        exp_fault = 32'd0;
        chk_all("midrst", 1'b1, 1'b1, 1'b0);
        Reset_H = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clock);
            #1;
            chk_all($sformatf("blocked edge %0d", k), 1'b1, 1'b1, 1'b0);
        end
        run_txn("rel", 5'b0, 32'd0, 0, -1, 0, -1, -1, -1);
        run_txn("postrst", S_CAN, 32'h0060_1000, 9, -1, 0, 7, -1, -1);

        // Random cycles against the model
        rand_clr = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sel = 5'b0;
                r   = $urandom_range(1, 300);
            end else begin
                sel = 5'($urandom_range(1, 31));
                r   = $urandom_range(1, 20);
            end
            d = $urandom_range(0, 20);
            model(sel, r, d, dfrom, bfrom);
            run_txn($sformatf("rnd%0d", i), sel, $urandom, r, d, $urandom_range(0, 2),
                    dfrom, bfrom, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
